// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score counter: FSM states, digit width,
// and the ADD_AMT clamp applied when an event is latched.
package score_pkg;
  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  function automatic logic [DIGIT_W-1:0] clamp_amt(input logic [DIGIT_W-1:0] amt);
    return (amt > BCD_NINE) ? BCD_NINE : amt;
  endfunction
endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder: digit + addend (each 0..9), decimal-adjusted result and carry.
module bcd_digit_adder
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic [DIGIT_W-1:0] addend,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               carry_out
);
  logic [DIGIT_W:0] sum;
  logic [DIGIT_W:0] sum_adj;

  always_comb begin
    sum       = {1'b0, digit} + {1'b0, addend};
    sum_adj   = sum - 5'd10;
    carry_out = (sum >= 5'd10);
    digit_out = carry_out ? sum_adj[DIGIT_W-1:0] : sum[DIGIT_W-1:0];
  end
endmodule

// File: rtl/score_bcd_counter.sv
// Digit-serial BCD score accumulator, one digit rippled per cycle, 1-deep event pending slot.
// Optional high-score register enabled by defining SCORE_HIGH_EN.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   CLEAR,
  input  logic                   HIT,
  input  logic [3:0]             ADD_AMT,
  output logic [4*DIGITS-1:0]    SCORE_BCD,
  output logic                   BUSY,
  output logic                   UPDATED,
  output logic                   OVERFLOW,
  output logic                   DROP,
  output logic [4*DIGITS-1:0]    HI_BCD
);
  localparam int unsigned K_W = $clog2(DIGITS);

  state_t                     state, state_d;
  logic                       hit_q;
  logic                       pending;
  logic [DIGIT_W-1:0]         amt;
  logic [K_W-1:0]             k;
  logic [DIGIT_W*DIGITS-1:0]  score;
  logic                       overflow;
  logic                       drop;

  logic                       event_hit;
  logic                       busy;
  logic                       start;
  logic                       last_digit;
  logic [DIGIT_W-1:0]         cur_digit;
  logic [DIGIT_W-1:0]         addend;
  logic [DIGIT_W-1:0]         add_digit;
  logic                       add_carry;

  assign event_hit = HIT & ~hit_q;
  assign busy      = (state != IDLE);

  // Digits above 0 are only visited while a carry is live, so their addend is always 1.
  always_comb begin
    cur_digit  = score[DIGIT_W*k +: DIGIT_W];
    addend     = (k == '0) ? amt : DIGIT_W'(1);
    last_digit = (k == K_W'(DIGITS-1));
  end

  bcd_digit_adder u_adder (
    .digit     (cur_digit),
    .addend    (addend),
    .digit_out (add_digit),
    .carry_out (add_carry)
  );

  always_comb begin
    state_d = state;
    start   = 1'b0;
    unique case (state)
      IDLE: if (event_hit || pending) begin
        state_d = ADD;
        start   = 1'b1;
      end
      ADD: if (!add_carry || last_digit) state_d = DONE;
      DONE: begin
        if (pending) begin
          state_d = ADD;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (CLEAR) begin
      state_d = IDLE;
      start   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      hit_q    <= 1'b0;
      pending  <= 1'b0;
      amt      <= '0;
      k        <= '0;
      score    <= '0;
      overflow <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state <= state_d;
      hit_q <= HIT;
      drop  <= 1'b0;
      if (CLEAR) begin
        score    <= '0;
        overflow <= 1'b0;
        pending  <= 1'b0;
        k        <= '0;
      end else begin
        if (start) begin
          amt <= clamp_amt(ADD_AMT);
          k   <= '0;
        end
        // In DONE the pending slot is freed by this cycle's start, so a new event can refill it.
        if (event_hit && busy) begin
          if (pending && !start) drop <= 1'b1;
          else                   pending <= 1'b1;
        end else if (start) begin
          pending <= 1'b0;
        end
        if (state == ADD) begin
          score[DIGIT_W*k +: DIGIT_W] <= add_digit;
          if (add_carry && last_digit) begin
            overflow <= 1'b1;
            if (SATURATE) score <= {DIGITS{BCD_NINE}};
          end else if (add_carry) begin
            k <= k + 1'b1;
          end
        end
      end
    end
  end

  assign SCORE_BCD = score;
  assign BUSY      = busy;
  assign UPDATED   = (state == DONE);
  assign OVERFLOW  = overflow;
  assign DROP      = drop;

`ifdef SCORE_HIGH_EN
  logic [DIGIT_W*DIGITS-1:0] hi_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                                   hi_q <= '0;
    else if (!CLEAR && state == DONE && score > hi_q) hi_q <= score;
  end

  assign HI_BCD = hi_q;
`else
  assign HI_BCD = '0;
`endif
endmodule
